guess_display_sequencer: RTL and testbench

- Sequences the sprite overlay in the VGA path for the guessing game.
- Takes the raw player button and switch guess, then debounces, compares against the answer and picks the sprite: up arrow, down arrow, correct mark, or none.
- Sprite changes are committed only on the frame-boundary strobe from the timing generator, so no frame tears. Each sprite is held for a programmable number of frames.
- Sits between the board I/O and the VGAController pixel mux.

---
 rtl/guess_display_sequencer_pkg.sv | 21 ++
 rtl/guess_display_sequencer_button_debouncer.sv | 54 +++++
 rtl/guess_display_sequencer.sv | 161 ++++++++++++++++
 tb/tb_guess_display_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_display_sequencer_pkg.sv
// Purpose : shared definitions for the guessing-game sprite sequencer.
//           The sprite codes are also consumed by the VGAController pixel mux,
//           so their values must stay stable.
// Contents: sprite_t / SPR_* sprite codes, state_t sequencer FSM states.
package guess_display_sequencer_pkg;

  typedef logic [1:0] sprite_t;

  localparam sprite_t SPR_NONE    = 2'd0;
  localparam sprite_t SPR_UP      = 2'd1;
  localparam sprite_t SPR_DOWN    = 2'd2;
  localparam sprite_t SPR_CORRECT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SHOW       = 2'd2,
    ST_WON        = 2'd3
  } state_t;

endpackage

// File: rtl/guess_display_sequencer_button_debouncer.sv
// Purpose : conditions the raw player push button.
//           2-flop synchronizer, stability counter, rising-edge press pulse.
// Ports   : clk       - system clock
//           reset     - asynchronous active-low reset
//           i_button  - raw asynchronous button level
//           o_press   - one-cycle pulse in the cycle after the debounced
//                       level rises
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_button,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_prev;
  logic [CNT_W-1:0] r_cnt;

  // The counter only runs while the synchronized level differs from the
  // accepted level. For a two-level signal this is the same as clearing on
  // every change of the synchronized level: a change either makes it equal
  // to the accepted level (clear) or starts a fresh count from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_level      <= 1'b0;
      r_level_prev <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1      <= i_button;
      r_sync2      <= r_sync1;
      r_level_prev <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_level & ~r_level_prev;

endmodule

// File: rtl/guess_display_sequencer.sv
// Purpose : sprite overlay sequencer for the guessing game VGA path.
//           Debounces the player button, compares guess vs answer at each
//           accepted press and commits the chosen sprite only on the frame
//           boundary strobe, holding UP/DOWN for HOLD_FRAMES frames.
// Ports   : clk, reset (async active-low)
//           playerButton - raw button;  guess/answer - sampled at a press
//           screenEnd    - frame-boundary pulse; new_round - clears the game
//           sprite_sel   - 0 NONE, 1 UP, 2 DOWN, 3 CORRECT
//           attempts     - saturating accepted-press count
//           game_won     - high while won;  press_ack - accepted-press pulse
module guess_display_sequencer
  import guess_display_sequencer_pkg::*;
#(
  parameter int GUESS_W         = 15,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_FRAMES     = 120,
  parameter int ATTEMPT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 playerButton,
  input  logic [GUESS_W-1:0]   guess,
  input  logic [GUESS_W-1:0]   answer,
  input  logic                 screenEnd,
  input  logic                 new_round,
  output logic [1:0]           sprite_sel,
  output logic [ATTEMPT_W-1:0] attempts,
  output logic                 game_won,
  output logic                 press_ack
);

  localparam int FRM_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [FRM_W-1:0] HOLD_LAST = FRM_W'(HOLD_FRAMES - 1);

  state_t                r_state;
  state_t                w_state_next;
  sprite_t               r_sprite;
  sprite_t               w_sprite_next;
  sprite_t               r_pending;
  sprite_t               w_pending_next;
  logic [FRM_W-1:0]      r_frame;
  logic [FRM_W-1:0]      w_frame_next;
  logic [ATTEMPT_W-1:0]  r_attempts;
  logic [ATTEMPT_W-1:0]  w_attempts_next;
  logic                  r_ack;
  logic                  w_ack_next;

  logic                  w_press;
  logic                  w_press_ok;
  sprite_t               w_cmp;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .i_button(playerButton),
    .o_press (w_press)
  );

  // new_round takes priority over a coincident press; presses do not count
  // once the round is won.
  assign w_press_ok = w_press & ~new_round & (r_state != ST_WON);

  always_comb begin
    if (guess < answer) begin
      w_cmp = SPR_UP;
    end else if (guess > answer) begin
      w_cmp = SPR_DOWN;
    end else begin
      w_cmp = SPR_CORRECT;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sprite_next   = r_sprite;
    w_pending_next  = r_pending;
    w_frame_next    = r_frame;
    w_attempts_next = r_attempts;
    w_ack_next      = 1'b0;

    if (w_press_ok) begin
      w_pending_next = w_cmp;
      w_ack_next     = 1'b1;
      if (r_attempts != '1) begin
        w_attempts_next = r_attempts + 1'b1;
      end
    end

    if (new_round) begin
      w_state_next    = ST_IDLE;
      w_sprite_next   = SPR_NONE;
      w_attempts_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_sprite_next = SPR_NONE;
          // A press coinciding with screenEnd still waits for the next frame.
          if (w_press_ok) begin
            w_state_next = ST_WAIT_FRAME;
          end
        end
        ST_WAIT_FRAME: begin
          // A press in the same cycle as screenEnd is the latest press, so
          // its freshly computed result is the one committed.
          if (screenEnd) begin
            w_sprite_next = w_pending_next;
            w_frame_next  = '0;
            w_state_next  = (w_pending_next == SPR_CORRECT) ? ST_WON : ST_SHOW;
          end
        end
        ST_SHOW: begin
          // A new press keeps the current sprite up until the next frame
          // boundary, where it is replaced without a blank frame.
          if (w_press_ok) begin
            w_state_next = ST_WAIT_FRAME;
          end else if (screenEnd) begin
            if (r_frame == HOLD_LAST) begin
              w_sprite_next = SPR_NONE;
              w_state_next  = ST_IDLE;
            end else begin
              w_frame_next = r_frame + 1'b1;
            end
          end
        end
        ST_WON: begin
          w_sprite_next = SPR_CORRECT;
        end
        default: begin
          w_state_next  = ST_IDLE;
          w_sprite_next = SPR_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_sprite   <= SPR_NONE;
      r_pending  <= SPR_NONE;
      r_frame    <= '0;
      r_attempts <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sprite   <= w_sprite_next;
      r_pending  <= w_pending_next;
      r_frame    <= w_frame_next;
      r_attempts <= w_attempts_next;
      r_ack      <= w_ack_next;
    end
  end

  assign sprite_sel = r_sprite;
  assign attempts   = r_attempts;
  assign game_won   = (r_state == ST_WON);
  assign press_ack  = r_ack;

endmodule

// File: tb/tb_guess_display_sequencer.sv
// Purpose : self-checking bench for guess_display_sequencer. Two instances
//           (HOLD_FRAMES=3 and HOLD_FRAMES=1) share one stimulus stream and
//           are compared every cycle against a behavioural game model.
module tb_guess_display_sequencer;

  localparam int GW = 15;
  localparam int DB = 4;
  localparam int HF = 3;
  localparam int AW = 8;
  localparam int ATT_MAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn;
  logic [GW-1:0] guess;
  logic [GW-1:0] answer;
  logic          se;
  logic          nr;

  logic [1:0]    spr0, spr1;
  logic [AW-1:0] att0, att1;
  logic          won0, won1, ack0, ack1;

  always #5 clk = ~clk;

  guess_display_sequencer #(
    .GUESS_W(GW), .DEBOUNCE_CYCLES(DB), .HOLD_FRAMES(HF), .ATTEMPT_W(AW)
  ) dut0 (
    .clk(clk), .reset(reset), .playerButton(btn), .guess(guess), .answer(answer),
    .screenEnd(se), .new_round(nr), .sprite_sel(spr0), .attempts(att0),
    .game_won(won0), .press_ack(ack0)
  );

  guess_display_sequencer #(
    .GUESS_W(GW), .DEBOUNCE_CYCLES(DB), .HOLD_FRAMES(1), .ATTEMPT_W(AW)
  ) dut1 (
    .clk(clk), .reset(reset), .playerButton(btn), .guess(guess), .answer(answer),
    .screenEnd(se), .new_round(nr), .sprite_sel(spr1), .attempts(att1),
    .game_won(won1), .press_ack(ack1)
  );

  int checks = 0;
  int errors = 0;
  int n_ack  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button: the synchronized level is the raw level two clocks late; the
  // accepted level flips once the last DB synchronized samples all agree on
  // the other value. A press is a rise of the accepted level.
  // Game: one pending result, a "waiting for frame" flag, and per instance
  // a count of frames left before the sprite is cleared.
  bit m_s1, m_s2, m_deb, m_deb_prev;
  bit hist[$];
  int m_att, m_pend;
  bit m_won, m_wait, m_ack;
  int m_spr[2];
  int m_left[2];
  int hold[2];

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0;
    hist.delete();
    m_att = 0; m_pend = 0; m_won = 0; m_wait = 0; m_ack = 0;
    for (int i = 0; i < 2; i++) begin
      m_spr[i] = 0;
      m_left[i] = 0;
    end
  endtask

  task automatic model_step();
    bit press, was_wait, samp, agree;
    press = m_deb && !m_deb_prev;
    m_ack = 0;
    if (nr) begin
      m_att = 0; m_won = 0; m_wait = 0;
      for (int i = 0; i < 2; i++) begin
        m_spr[i] = 0;
        m_left[i] = 0;
      end
    end else if (!m_won) begin
      was_wait = m_wait;
      if (press) begin
        m_pend = (guess < answer) ? 1 : ((guess > answer) ? 2 : 3);
        if (m_att < ATT_MAX) m_att++;
        m_ack = 1;
        m_wait = 1;
      end
      if (se) begin
        if (was_wait) begin
          m_wait = 0;
          if (m_pend == 3) m_won = 1;
          for (int i = 0; i < 2; i++) begin
            m_spr[i] = m_pend;
            m_left[i] = hold[i];
          end
        end else if (!press) begin
          for (int i = 0; i < 2; i++) begin
            if (m_left[i] > 0) begin
              m_left[i]--;
              if (m_left[i] == 0) m_spr[i] = 0;
            end
          end
        end
      end
    end
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = btn;
    m_deb_prev = m_deb;
    hist.push_back(samp);
    if (hist.size() > DB) void'(hist.pop_front());
    if (hist.size() == DB) begin
      agree = 1;
      foreach (hist[k]) if (hist[k] != samp) agree = 0;
      if (agree && samp != m_deb) m_deb = samp;
    end
  endtask

  // One clock: model advances with the inputs the DUT sees at this edge,
  // outputs are compared on the following falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (ack0) n_ack++;
    chk("spr0", 32'(spr0), 32'(m_spr[0]));
    chk("spr1", 32'(spr1), 32'(m_spr[1]));
    chk("att0", 32'(att0), 32'(m_att));
    chk("att1", 32'(att1), 32'(m_att));
    chk("won0", 32'(won0), 32'(m_won));
    chk("won1", 32'(won1), 32'(m_won));
    chk("ack0", 32'(ack0), 32'(m_ack));
    chk("ack1", 32'(ack1), 32'(m_ack));
    if (m_ack)
      $display("press: pending=%0d attempts=%0d t=%0t", m_pend, m_att, $time);
    se = 0;
    nr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic frame();
    idle(2);
    se = 1;
    cycle();
  endtask

  task automatic press();
    btn = 1;
    idle(DB + 6);
    btn = 0;
    idle(DB + 4);
  endtask

  task automatic new_round_pulse();
    nr = 1;
    cycle();
  endtask

  initial begin
    int lat, n0, seg;
    bit hit;
    hold[0] = HF;
    hold[1] = 1;
    reset = 0; btn = 0; guess = '0; answer = '0; se = 0; nr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_spr", 32'(spr0), 32'd0);
    chk("rst_att", 32'(att0), 32'd0);
    chk("rst_won", 32'(won0), 32'd0);
    chk("rst_ack", 32'(ack0), 32'd0);
    reset = 1;

    // 1: clean UP press, latency and hold of three frames
    guess = GW'(5); answer = GW'(9);
    btn = 1; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (ack0) begin
        lat = i;
        break;
      end
    end
    chk("t1_latency", 32'(lat), 32'd7);
    chk("t1_att", 32'(att0), 32'd1);
    btn = 0; idle(10);
    chk("t1_wait_none", 32'(spr0), 32'd0);
    frame(); chk("t1_up", 32'(spr0), 32'd1);
    frame(); chk("t1_hold1", 32'(spr0), 32'd1);
    frame(); chk("t1_hold2", 32'(spr0), 32'd1);
    frame(); chk("t1_cleared", 32'(spr0), 32'd0);

    // 2: bouncing button gives exactly one press
    new_round_pulse(); idle(3);
    n0 = n_ack;
    for (int k = 0; k < 4; k++) begin
      btn = ~btn;
      idle(2);
    end
    btn = 1; idle(12);
    chk("t2_one_ack", 32'(n_ack - n0), 32'd1);
    chk("t2_att", 32'(att0), 32'd1);
    btn = 0; idle(10);

    // 3: correct guess, presses ignored while won, new_round clears
    new_round_pulse();
    guess = GW'(12); answer = GW'(12);
    press(); frame();
    chk("t3_correct", 32'(spr0), 32'd3);
    chk("t3_won", 32'(won0), 32'd1);
    press(); press(); press();
    chk("t3_att_frozen", 32'(att0), 32'd1);
    new_round_pulse();
    chk("t3_nr_spr", 32'(spr0), 32'd0);
    chk("t3_nr_att", 32'(att0), 32'd0);
    chk("t3_nr_won", 32'(won0), 32'd0);

    // 4: DOWN then UP during SHOW switches without a blank frame
    guess = GW'(20); answer = GW'(9);
    press(); frame();
    chk("t4_down", 32'(spr0), 32'd2);
    guess = GW'(3);
    press();
    chk("t4_still_down", 32'(spr0), 32'd2);
    frame();
    chk("t4_up", 32'(spr0), 32'd1);
    chk("t4_att", 32'(att0), 32'd2);

    // 5: attempt counter saturation
    new_round_pulse();
    guess = GW'(1); answer = GW'(2);
    for (int i = 0; i < 256; i++) press();
    chk("t5_saturated", 32'(att0), 32'd255);

    // 6: asynchronous reset mid-SHOW, then new_round colliding with a press
    new_round_pulse();
    press(); frame();
    chk("t6_up", 32'(spr0), 32'd1);
    #2 reset = 0;
    #1;
    chk("t6_async_spr", 32'(spr0), 32'd0);
    chk("t6_async_att", 32'(att0), 32'd0);
    chk("t6_async_spr1", 32'(spr1), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    press();
    chk("t6_att1", 32'(att0), 32'd1);
    n0 = n_ack;
    btn = 1; hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_deb && !m_deb_prev) begin
        nr = 1;
        cycle();
        hit = 1;
        break;
      end
      cycle();
    end
    chk("t6_press_seen", 32'(hit), 32'd1);
    chk("t6_dropped_att", 32'(att0), 32'd0);
    chk("t6_dropped_ack", 32'(n_ack - n0), 32'd0);
    btn = 0; idle(10);

    // random phase
    seg = 0;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        btn = ~btn;
        seg = $urandom_range(1, 12);
      end
      seg--;
      guess  = GW'($urandom_range(0, 7));
      answer = GW'($urandom_range(0, 7));
      se = ($urandom_range(0, 9) == 0);
      nr = ($urandom_range(0, 249) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
